// File: rtl/reindeer_trap_controller_pkg.sv
// reindeer_trap_controller_pkg: shared machine-mode CSR addresses, trap FSM states, cause codes and mtvec modes.
package reindeer_trap_controller_pkg;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;
    typedef enum logic [1:0] {IDLE, ENTER, RETURN, REDIRECT} trap_state_t;
    localparam int CAUSE_M_TIMER_INT = 7;
    localparam int CAUSE_M_EXT_INT   = 11;
    localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;
endpackage

// File: rtl/reindeer_trap_target.sv
// reindeer_trap_target: combinational redirect target for trap entry (direct/vectored mtvec) or MRET (mepc).
module reindeer_trap_target
    import reindeer_trap_controller_pkg::*;
#(
    parameter int PC_BITWIDTH         = 32,
    parameter int EXCEPTION_CODE_BITS = 4
) (
    input  logic [PC_BITWIDTH-1:0]         mtvec_i,
    input  logic [PC_BITWIDTH-1:0]         mepc_i,
    input  logic                           is_mret_i,
    input  logic                           is_interrupt_i,
    input  logic [EXCEPTION_CODE_BITS-1:0] code_i,
    output logic [PC_BITWIDTH-1:0]         target_o
);
    logic [PC_BITWIDTH-1:0] base;
    always_comb begin
        base     = mtvec_i & ~PC_BITWIDTH'(3);
        target_o = is_mret_i ? (mepc_i & ~PC_BITWIDTH'(1))
                 : (mtvec_i[1:0] == MTVEC_MODE_VECTORED && is_interrupt_i) ? base + (PC_BITWIDTH'(code_i) << 2)
                 : base;
    end
endmodule

// File: rtl/reindeer_trap_controller.sv
// reindeer_trap_controller: machine-mode trap entry / MRET sequencer; captures cause state for the CSR file
// and holds a redirect to fetch until it is acknowledged.
module reindeer_trap_controller
    import reindeer_trap_controller_pkg::*;
#(
    parameter int PC_BITWIDTH         = 32,
    parameter int EXCEPTION_CODE_BITS = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           exception_req,
    input  logic [EXCEPTION_CODE_BITS-1:0] exception_code_in,
    input  logic [PC_BITWIDTH-1:0]         exception_pc_in,
    input  logic [PC_BITWIDTH-1:0]         exception_addr_in,
    input  logic [PC_BITWIDTH-1:0]         next_pc,
    input  logic                           int_window,
    input  logic                           mtip,
    input  logic                           meip,
    input  logic                           mtie,
    input  logic                           meie,
    input  logic                           mie,
    input  logic [PC_BITWIDTH-1:0]         mtvec,
    input  logic [PC_BITWIDTH-1:0]         mepc,
    input  logic                           mret_req,
    input  logic                           redirect_ack,
    output logic                           activate_exception,
    output logic                           is_interrupt,
    output logic [EXCEPTION_CODE_BITS-1:0] exception_code,
    output logic [PC_BITWIDTH-1:0]         exception_PC,
    output logic [PC_BITWIDTH-1:0]         exception_addr,
    output logic                           trap_ack,
    output logic                           mie_clear,
    output logic                           mret_active,
    output logic                           redirect_valid,
    output logic [PC_BITWIDTH-1:0]         redirect_pc,
    output logic                           busy
);
    trap_state_t                    state_q;
    logic                           activate_q, is_interrupt_q, trap_ack_q, mie_clear_q, mret_active_q, redirect_valid_q;
    logic [EXCEPTION_CODE_BITS-1:0] code_q;
    logic [PC_BITWIDTH-1:0]         pc_q, addr_q, redirect_pc_q, redirect_pc_d;
    logic                           ext_ok, tmr_ok;

    assign ext_ok = meip & meie & mie & int_window;
    assign tmr_ok = mtip & mtie & mie & int_window;

    reindeer_trap_target #(
        .PC_BITWIDTH        (PC_BITWIDTH),
        .EXCEPTION_CODE_BITS(EXCEPTION_CODE_BITS)
    ) u_target (
        .mtvec_i       (mtvec),
        .mepc_i        (mepc),
        .is_mret_i     (state_q == RETURN),
        .is_interrupt_i(is_interrupt_q),
        .code_i        (code_q),
        .target_o      (redirect_pc_d)
    );

    // Strobes default low every cycle; the captured cause fields hold until the next trap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            activate_q       <= 1'b0;
            is_interrupt_q   <= 1'b0;
            trap_ack_q       <= 1'b0;
            mie_clear_q      <= 1'b0;
            mret_active_q    <= 1'b0;
            redirect_valid_q <= 1'b0;
            code_q           <= '0;
            pc_q             <= '0;
            addr_q           <= '0;
            redirect_pc_q    <= '0;
        end else begin
            activate_q     <= 1'b0;
            is_interrupt_q <= 1'b0;
            trap_ack_q     <= 1'b0;
            mie_clear_q    <= 1'b0;
            mret_active_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (exception_req) begin
                        state_q     <= ENTER;
                        activate_q  <= 1'b1;
                        trap_ack_q  <= 1'b1;
                        mie_clear_q <= 1'b1;
                        code_q      <= exception_code_in;
                        pc_q        <= exception_pc_in;
                        addr_q      <= exception_addr_in;
                    end else if (mret_req) begin
                        state_q       <= RETURN;
                        mret_active_q <= 1'b1;
                        trap_ack_q    <= 1'b1;
                    end else if (ext_ok || tmr_ok) begin
                        state_q        <= ENTER;
                        activate_q     <= 1'b1;
                        is_interrupt_q <= 1'b1;
                        trap_ack_q     <= 1'b1;
                        mie_clear_q    <= 1'b1;
                        code_q         <= ext_ok ? EXCEPTION_CODE_BITS'(CAUSE_M_EXT_INT)
                                                 : EXCEPTION_CODE_BITS'(CAUSE_M_TIMER_INT);
                        pc_q           <= next_pc;
                        addr_q         <= '0;
                    end
                end
                ENTER, RETURN: begin
                    state_q          <= REDIRECT;
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= redirect_pc_d;
                end
                REDIRECT: begin
                    if (redirect_ack) begin
                        state_q          <= IDLE;
                        redirect_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign activate_exception = activate_q;
    assign is_interrupt       = is_interrupt_q;
    assign exception_code     = code_q;
    assign exception_PC       = pc_q;
    assign exception_addr     = addr_q;
    assign trap_ack           = trap_ack_q;
    assign mie_clear          = mie_clear_q;
    assign mret_active        = mret_active_q;
    assign redirect_valid     = redirect_valid_q;
    assign redirect_pc        = redirect_pc_q;
    assign busy               = state_q != IDLE;
endmodule

// File: tb/tb_reindeer_trap_controller.sv
// tb_reindeer_trap_controller: table-driven trap/MRET vectors plus priority, masking, backpressure and reset sequences.
module tb_reindeer_trap_controller;
    logic        clk = 1'b0, reset = 1'b1;
    logic        exception_req = 1'b0, mret_req = 1'b0, redirect_ack = 1'b0, int_window = 1'b0;
    logic        mtip = 1'b0, meip = 1'b0, mtie = 1'b0, meie = 1'b0, mie = 1'b0;
    logic [3:0]  exception_code_in = '0;
    logic [31:0] exception_pc_in = '0, exception_addr_in = '0, next_pc = '0, mtvec = '0, mepc = '0;
    logic        activate_exception, is_interrupt, trap_ack, mie_clear, mret_active, redirect_valid, busy;
    logic [3:0]  exception_code;
    logic [31:0] exception_PC, exception_addr, redirect_pc;
    int          pass_cnt = 0, total_cnt = 0;

    reindeer_trap_controller #(.PC_BITWIDTH(32), .EXCEPTION_CODE_BITS(4)) dut (
        .clk(clk), .reset(reset),
        .exception_req(exception_req), .exception_code_in(exception_code_in),
        .exception_pc_in(exception_pc_in), .exception_addr_in(exception_addr_in),
        .next_pc(next_pc), .int_window(int_window),
        .mtip(mtip), .meip(meip), .mtie(mtie), .meie(meie), .mie(mie),
        .mtvec(mtvec), .mepc(mepc), .mret_req(mret_req), .redirect_ack(redirect_ack),
        .activate_exception(activate_exception), .is_interrupt(is_interrupt),
        .exception_code(exception_code), .exception_PC(exception_PC), .exception_addr(exception_addr),
        .trap_ack(trap_ack), .mie_clear(mie_clear), .mret_active(mret_active),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        exc, mret, meip, mtip, en;
        logic [3:0]  code;
        logic [31:0] pc, addr, npc, mtvec, mepc;
        logic        e_int;
        logic [3:0]  e_code;
        logic [31:0] e_pc, e_addr, e_rpc;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(logic exc, logic [3:0] code, logic [31:0] pc, logic [31:0] addr, logic [31:0] npc,
                                logic mret, logic mp, logic tp, logic en, logic [31:0] tv, logic [31:0] ep,
                                logic e_int, logic [3:0] e_code, logic [31:0] e_pc, logic [31:0] e_addr,
                                logic [31:0] e_rpc);
        vec_t v;
        v.exc = exc; v.code = code; v.pc = pc; v.addr = addr; v.npc = npc;
        v.mret = mret; v.meip = mp; v.mtip = tp; v.en = en; v.mtvec = tv; v.mepc = ep;
        v.e_int = e_int; v.e_code = e_code; v.e_pc = e_pc; v.e_addr = e_addr; v.e_rpc = e_rpc;
        return v;
    endfunction

    function automatic logic [127:0] all_outs();
        return {activate_exception, is_interrupt, exception_code, exception_PC, exception_addr, trap_ack,
                mie_clear, mret_active, redirect_valid, redirect_pc, busy};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_redirect(input string tag);
        redirect_ack = 1'b1;
        tick();
        chk({tag, " rv_drop"}, redirect_valid, 0);
        chk({tag, " idle"}, busy, 0);
        redirect_ack = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int i);
        string t;
        t = $sformatf("vec%0d", i);
        exception_req = v.exc; exception_code_in = v.code; exception_pc_in = v.pc; exception_addr_in = v.addr;
        next_pc = v.npc; mret_req = v.mret; meip = v.meip; mtip = v.mtip;
        meie = v.en; mtie = v.en; mie = v.en; int_window = v.en; mtvec = v.mtvec; mepc = v.mepc;
        tick();
        chk({t, " trap_ack"}, trap_ack, 1);
        chk({t, " busy"}, busy, 1);
        if (v.mret) begin
            chk({t, " mret_active"}, mret_active, 1);
            chk({t, " no_activate"}, activate_exception, 0);
        end else begin
            chk({t, " activate"}, activate_exception, 1);
            chk({t, " mie_clear"}, mie_clear, 1);
            chk({t, " is_interrupt"}, is_interrupt, v.e_int);
            chk({t, " code"}, exception_code, v.e_code);
            chk({t, " pc"}, exception_PC, v.e_pc);
            chk({t, " addr"}, exception_addr, v.e_addr);
        end
        exception_req = 1'b0; mret_req = 1'b0; meip = 1'b0; mtip = 1'b0;
        tick();
        chk({t, " redirect_valid"}, redirect_valid, 1);
        chk({t, " redirect_pc"}, redirect_pc, v.e_rpc);
        chk({t, " no_reack"}, trap_ack, 0);
        finish_redirect(t);
    endtask

    initial begin
        //            exc code pc            addr           npc       mret mp tp en mtvec          mepc          int code e_pc          e_addr         e_rpc
        vecs[0] = mk(1, 2,  32'h100,      32'h104,       32'h0,    0,   0, 0, 0, 32'h80,       32'h0,        0,  2,  32'h100,      32'h104,       32'h80);
        vecs[1] = mk(0, 0,  32'h0,        32'h0,         32'h40,   0,   1, 0, 1, 32'h201,      32'h0,        1,  11, 32'h40,       32'h0,         32'h22C);
        vecs[2] = mk(0, 0,  32'h0,        32'h0,         32'h88,   0,   0, 1, 1, 32'h201,      32'h0,        1,  7,  32'h88,       32'h0,         32'h21C);
        vecs[3] = mk(0, 0,  32'h0,        32'h0,         32'h90,   0,   0, 1, 1, 32'h302,      32'h0,        1,  7,  32'h90,       32'h0,         32'h300);
        vecs[4] = mk(0, 0,  32'h0,        32'h0,         32'h0,    1,   0, 0, 0, 32'h80,       32'h123,      0,  0,  32'h0,        32'h0,         32'h122);
        vecs[5] = mk(1, 5,  32'h2000,     32'hDEADBEEF,  32'h77,   0,   1, 0, 1, 32'h201,      32'h0,        0,  5,  32'h2000,     32'hDEADBEEF,  32'h200);
        vecs[6] = mk(0, 0,  32'h0,        32'h0,         32'h5000, 0,   1, 0, 1, 32'hFFFFFFF1, 32'h0,        1,  11, 32'h5000,     32'h0,         32'h1C);
        vecs[7] = mk(0, 0,  32'h0,        32'h0,         32'h60,   0,   1, 1, 1, 32'h1001,     32'h0,        1,  11, 32'h60,       32'h0,         32'h102C);
        vecs[8] = mk(0, 0,  32'h0,        32'h0,         32'h64,   1,   1, 0, 1, 32'h80,       32'hFFFFFFFF, 0,  0,  32'h0,        32'h0,         32'hFFFFFFFE);
        vecs[9] = mk(1, 15, 32'hFFFFFFFC, 32'h0,         32'h0,    0,   0, 0, 0, 32'hFFFFFFFD, 32'h0,        0,  15, 32'hFFFFFFFC, 32'h0,         32'hFFFFFFFC);

        repeat (2) tick();
        chk("reset_outs", all_outs(), 0);
        reset = 1'b0;
        tick();
        chk("post_reset_outs", all_outs(), 0);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Priority: everything requested at once, then the held lower-priority requests drain in order.
        exception_req = 1; exception_code_in = 3; exception_pc_in = 32'h700; exception_addr_in = 32'h704;
        mret_req = 1; mepc = 32'h123; meip = 1; mtip = 1; meie = 1; mtie = 1; mie = 1; int_window = 1;
        mtvec = 32'h80; next_pc = 32'h44;
        tick();
        chk("prio exc_first", {activate_exception, is_interrupt, mret_active, exception_code}, {3'b100, 4'd3});
        exception_req = 0;
        tick();
        chk("prio exc_rpc", redirect_pc, 32'h80);
        chk("prio busy_ignored", trap_ack, 0);
        finish_redirect("prio exc");
        tick();
        chk("prio mret_second", {mret_active, trap_ack, activate_exception}, 3'b110);
        mret_req = 0;
        tick();
        chk("prio mret_rpc", redirect_pc, 32'h122);
        finish_redirect("prio mret");
        tick();
        chk("prio ext_third", {activate_exception, is_interrupt, exception_code, exception_PC}, {2'b11, 4'd11, 32'h44});
        meip = 0; mtip = 0;
        tick();
        chk("prio ext_rpc", redirect_pc, 32'h80);
        finish_redirect("prio ext");

        // Masked timer interrupt stays pending until mie is set.
        mtip = 1; mtie = 1; mie = 0; meie = 0; int_window = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("mask busy%0d", i), busy, 0);
        end
        mie = 1;
        tick();
        chk("mask taken", {activate_exception, is_interrupt, exception_code}, {2'b11, 4'd7});
        mtip = 0;
        tick();
        chk("mask rpc", {redirect_valid, redirect_pc}, {1'b1, 32'h80});
        finish_redirect("mask");

        // Ack outside REDIRECT is ignored, then backpressure, then reset aborts the redirect.
        redirect_ack = 1;
        tick();
        chk("ack_idle busy", busy, 0);
        redirect_ack = 0;
        exception_req = 1; exception_code_in = 6; exception_pc_in = 32'h900; exception_addr_in = 32'h904;
        mtvec = 32'h80;
        tick();
        exception_req = 0;
        redirect_ack = 1;
        tick();
        redirect_ack = 0;
        chk("ack_enter ignored", {redirect_valid, redirect_pc}, {1'b1, 32'h80});
        mtvec = 32'h400; mepc = 32'h600;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp hold%0d", i), {redirect_valid, redirect_pc, busy}, {1'b1, 32'h80, 1'b1});
        end
        #2 reset = 1;
        #1 chk("async_reset outs", all_outs(), 0);
        tick();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("no_resume%0d", i), all_outs(), 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
